// File: rtl/io_od_if.sv
// Command/status bundle between the I2C bit engine and one open-drain line.
// The bit engine (master) drives commands and the filtered line level.
interface io_od_if;
  logic cmd_valid;
  logic cmd_level;
  logic cmd_ready;
  logic abort;
  logic line_in;
  logic oe;
  logic busy;
  logic done;
  logic stretch;
  logic arb_lost;
  logic fault;
  logic timeout;

  modport master (
    output cmd_valid, cmd_level, abort, line_in,
    input  cmd_ready, oe, busy, done, stretch,
    input  arb_lost, fault, timeout
  );

  modport slave (
    input  cmd_valid, cmd_level, abort, line_in,
    output cmd_ready, oe, busy, done, stretch,
    output arb_lost, fault, timeout
  );
endinterface

// File: rtl/io_od_driver.sv
// Open-drain I2C line driver: hold timing, oe drive, line verification,
// clock-stretch wait (SCL) or arbitration-loss detection (SDA).
module io_od_driver #(
  parameter int HOLD_CYC    = 4,
  parameter int SETTLE_CYC  = 6,
  parameter int TIMEOUT_CYC = 4096,
  parameter int IS_SCL      = 1
) (
  input logic    clk_sync,
  input logic    reset_n,
  io_od_if.slave bus
);

  localparam int MX1 =
    (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int MXP =
    (MX1 > TIMEOUT_CYC) ? MX1 : TIMEOUT_CYC;
  localparam int CW = $clog2(MXP + 1);

  localparam logic [CW-1:0] HOLD_LD =
    CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] ONE    = CW'(1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] SETTLE    = 2'd2;
  localparam logic [1:0] WAIT_HIGH = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          lvl;
  logic          oe_q;
  logic          done_q;
  logic          fault_q;
  logic          arb_q;
  logic          tmo_q;

  // Sequencer: accept, hold, drive, settle, verify, optional stretch wait.
  always_ff @(posedge clk_sync or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lvl     <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      arb_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      arb_q   <= 1'b0;
      tmo_q   <= 1'b0;
      if (bus.abort) begin
        state <= IDLE;
        oe_q  <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (1'b1)
          (state == IDLE): begin
            if (bus.cmd_valid) begin
              lvl <= bus.cmd_level;
              if (HOLD_CYC == 0) begin
                oe_q  <= ~bus.cmd_level;
                state <= SETTLE;
                cnt   <= SET_LD;
              end else begin
                state <= HOLD;
                cnt   <= HOLD_LD;
              end
            end
          end
          (state == HOLD): begin
            if (cnt == '0) begin
              oe_q  <= ~lvl;
              state <= SETTLE;
              cnt   <= SET_LD;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          (state == SETTLE): begin
            if (cnt != '0) begin
              cnt <= cnt - ONE;
            end else if (bus.line_in == lvl) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else if (!lvl) begin
              fault_q <= 1'b1;
              state   <= IDLE;
            end else if (IS_SCL == 0) begin
              arb_q <= 1'b1;
              state <= IDLE;
            end else begin
              state <= WAIT_HIGH;
              cnt   <= TO_LD;
            end
          end
          (state == WAIT_HIGH): begin
            if (bus.line_in) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else if (cnt <= ONE) begin
              tmo_q <= 1'b1;
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        endcase
      end
    end
  end

  // Status outputs decoded from state and pulse registers.
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.stretch   = (state == WAIT_HIGH);
    bus.oe        = oe_q;
    bus.done      = done_q;
    bus.fault     = fault_q;
    bus.arb_lost  = arb_q;
    bus.timeout   = tmo_q;
  end

endmodule

// File: tb/tb_io_od_driver.sv
// Bench for io_od_driver: SCL instance (A) and SDA instance with zero hold (B),
// checked cycle by cycle against an event-time reference model.
module tb_io_od_driver;
  localparam int HA = 4;
  localparam int SA = 6;
  localparam int TA = 32;
  localparam int HB = 0;
  localparam int SB = 6;

  logic clk_sync;
  logic reset_n;
  io_od_if ifa ();
  io_od_if ifb ();

  int checks;
  int failures;
  bit ma, fa, mb, fb;
  bit moe_a, moe_b;
  logic [1:0] pipe_a = 2'b11;
  logic [1:0] pipe_b = 2'b11;
  logic [7:0] st_a, st_b;

  io_od_driver #(
    .HOLD_CYC(HA), .SETTLE_CYC(SA), .TIMEOUT_CYC(TA), .IS_SCL(1)
  ) dut_a (
    .clk_sync(clk_sync), .reset_n(reset_n), .bus(ifa)
  );

  io_od_driver #(
    .HOLD_CYC(HB), .SETTLE_CYC(SB), .TIMEOUT_CYC(TA), .IS_SCL(0)
  ) dut_b (
    .clk_sync(clk_sync), .reset_n(reset_n), .bus(ifb)
  );

  initial clk_sync = 1'b0;
  always #5 clk_sync = ~clk_sync;

  // Pad model: released line follows ~oe through a 2-stage sync path.
  always @(posedge clk_sync) begin
    pipe_a <= {pipe_a[0], ~ifa.oe};
    pipe_b <= {pipe_b[0], ~ifb.oe};
  end
  assign ifa.line_in = ma ? fa : pipe_a[1];
  assign ifb.line_in = mb ? fb : pipe_b[1];

  assign st_a = {ifa.cmd_ready, ifa.oe, ifa.busy, ifa.stretch,
                 ifa.done, ifa.fault, ifa.arb_lost, ifa.timeout};
  assign st_b = {ifb.cmd_ready, ifb.oe, ifb.busy, ifb.stretch,
                 ifb.done, ifb.fault, ifb.arb_lost, ifb.timeout};

  // Reference: k cycles after accept. oe flips at hold, outcome at
  // hold+settle+wlen; kind 0 done, 1 fault, 2 arb_lost, 3 timeout.
  function automatic logic [7:0] exp_vec(int k, int h, int s,
      bit old_oe, bit lvl, int kind, int wlen);
    int e;
    bit o, b, st;
    e  = h + s + wlen;
    o  = (k >= h) ? !lvl : old_oe;
    b  = (k < e);
    st = (k >= h + s) && (k < e);
    return {!b, o, b, st,
            (k == e) && (kind == 0), (k == e) && (kind == 1),
            (k == e) && (kind == 2), (k == e) && (kind == 3)};
  endfunction

  task automatic issue_a(input bit lvl);
    @(negedge clk_sync);
    ifa.cmd_valid = 1'b1;
    ifa.cmd_level = lvl;
    @(posedge clk_sync);
    #1;
    ifa.cmd_valid = 1'b0;
  endtask

  task automatic issue_b(input bit lvl);
    @(negedge clk_sync);
    ifb.cmd_valid = 1'b1;
    ifb.cmd_level = lvl;
    @(posedge clk_sync);
    #1;
    ifb.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (st_a !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_a got=%b exp=%b", st_a, 8'b1000_0000);
    end
    checks++;
    if (st_b !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_b got=%b exp=%b", st_b, 8'b1000_0000);
    end
  endtask

  task automatic test_pull_low();
    logic [7:0] e;
    ma = 1'b0;
    issue_a(1'b0);
    for (int k = 0; k <= HA + SA + 3; k++) begin
      if (k > 0) begin @(posedge clk_sync); #1; end
      e = exp_vec(k, HA, SA, moe_a, 1'b0, 0, 0);
      checks++;
      if (st_a !== e) begin
        failures++;
        $display("FAIL pull_low k=%0d got=%b exp=%b", k, st_a, e);
      end
    end
    moe_a = 1'b1;
  endtask

  task automatic test_stretch();
    logic [7:0] e;
    ma = 1'b1;
    fa = 1'b0;
    issue_a(1'b1);
    for (int k = 0; k <= HA + SA + 20 + 2; k++) begin
      if (k > 0) begin @(posedge clk_sync); #1; end
      e = exp_vec(k, HA, SA, moe_a, 1'b1, 0, 20);
      checks++;
      if (st_a !== e) begin
        failures++;
        $display("FAIL stretch k=%0d got=%b exp=%b", k, st_a, e);
      end
      if (k == HA + SA + 19) fa = 1'b1;
    end
    moe_a = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] e;
    ma = 1'b1;
    fa = 1'b0;
    issue_a(1'b1);
    for (int k = 0; k <= HA + SA + TA + 3; k++) begin
      if (k > 0) begin @(posedge clk_sync); #1; end
      e = exp_vec(k, HA, SA, moe_a, 1'b1, 3, TA);
      checks++;
      if (st_a !== e) begin
        failures++;
        $display("FAIL timeout k=%0d got=%b exp=%b", k, st_a, e);
      end
    end
    moe_a = 1'b0;
  endtask

  task automatic test_fault();
    logic [7:0] e;
    ma = 1'b1;
    fa = 1'b1;
    issue_a(1'b0);
    for (int k = 0; k <= HA + SA + 4; k++) begin
      if (k > 0) begin @(posedge clk_sync); #1; end
      e = exp_vec(k, HA, SA, moe_a, 1'b0, 1, 0);
      checks++;
      if (st_a !== e) begin
        failures++;
        $display("FAIL fault k=%0d got=%b exp=%b", k, st_a, e);
      end
    end
    moe_a = 1'b1;
  endtask

  task automatic test_abort();
    ma = 1'b0;
    issue_a(1'b0);
    @(posedge clk_sync); #1;
    @(negedge clk_sync);
    ifa.abort = 1'b1;
    @(posedge clk_sync); #1;
    ifa.abort = 1'b0;
    checks++;
    if (st_a !== 8'b1000_0000) begin
      failures++;
      $display("FAIL abort_hold got=%b exp=%b", st_a, 8'b1000_0000);
    end
    ma = 1'b1;
    fa = 1'b0;
    issue_a(1'b1);
    repeat (HA + SA + 3) @(posedge clk_sync);
    #1;
    checks++;
    if (st_a !== 8'b0011_0000) begin
      failures++;
      $display("FAIL abort_pre_wait got=%b exp=%b", st_a, 8'b0011_0000);
    end
    @(negedge clk_sync);
    ifa.abort = 1'b1;
    @(posedge clk_sync); #1;
    ifa.abort = 1'b0;
    for (int k = 0; k < TA + 4; k++) begin
      checks++;
      if (st_a !== 8'b1000_0000) begin
        failures++;
        $display("FAIL abort_wait k=%0d got=%b exp=%b",
                 k, st_a, 8'b1000_0000);
      end
      @(posedge clk_sync); #1;
    end
    @(negedge clk_sync);
    ifa.abort     = 1'b1;
    ifa.cmd_valid = 1'b1;
    ifa.cmd_level = 1'b0;
    @(posedge clk_sync); #1;
    ifa.abort     = 1'b0;
    ifa.cmd_valid = 1'b0;
    @(posedge clk_sync); #1;
    checks++;
    if (st_a !== 8'b1000_0000) begin
      failures++;
      $display("FAIL abort_idle_cmd got=%b exp=%b", st_a, 8'b1000_0000);
    end
    moe_a = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    ma = 1'b0;
    issue_a(1'b0);
    for (int k = 0; k <= HA + 2; k++) begin
      if (k > 0) begin @(posedge clk_sync); #1; end
      e = exp_vec(k, HA, SA, moe_a, 1'b0, 0, 0);
      checks++;
      if (st_a !== e) begin
        failures++;
        $display("FAIL areset_pre k=%0d got=%b exp=%b", k, st_a, e);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (st_a !== 8'b1000_0000) begin
      failures++;
      $display("FAIL areset got=%b exp=%b", st_a, 8'b1000_0000);
    end
    @(negedge clk_sync);
    reset_n = 1'b1;
    moe_a = 1'b0;
    repeat (3) @(posedge clk_sync);
    #1;
  endtask

  task automatic test_random();
    logic [7:0] e;
    bit lvl, frc, f, ln;
    int kind;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_sync);
      #1;
      lvl = 1'($urandom_range(0, 1));
      frc = ($urandom_range(0, 2) == 0);
      f   = lvl ? 1'b1 : 1'($urandom_range(0, 1));
      ma  = frc;
      fa  = f;
      ln  = frc ? f : lvl;
      kind = (ln == lvl) ? 0 : 1;
      issue_a(lvl);
      for (int k = 0; k <= HA + SA + 1; k++) begin
        if (k > 0) begin @(posedge clk_sync); #1; end
        e = exp_vec(k, HA, SA, moe_a, lvl, kind, 0);
        checks++;
        if (st_a !== e) begin
          failures++;
          $display("FAIL random n=%0d k=%0d got=%b exp=%b",
                   n, k, st_a, e);
        end
      end
      moe_a = !lvl;
    end
  endtask

  task automatic test_arb_lost();
    logic [7:0] e;
    mb = 1'b1;
    fb = 1'b0;
    issue_b(1'b1);
    for (int k = 0; k <= HB + SB + 3; k++) begin
      if (k > 0) begin @(posedge clk_sync); #1; end
      e = exp_vec(k, HB, SB, moe_b, 1'b1, 2, 0);
      checks++;
      if (st_b !== e) begin
        failures++;
        $display("FAIL arb_lost k=%0d got=%b exp=%b", k, st_b, e);
      end
    end
    moe_b = 1'b0;
  endtask

  task automatic test_hold0_same_level();
    logic [7:0] e;
    mb = 1'b0;
    for (int n = 0; n < 2; n++) begin
      issue_b(1'b0);
      for (int k = 0; k <= HB + SB + 2; k++) begin
        if (k > 0) begin @(posedge clk_sync); #1; end
        e = exp_vec(k, HB, SB, moe_b, 1'b0, 0, 0);
        checks++;
        if (st_b !== e) begin
          failures++;
          $display("FAIL hold0 n=%0d k=%0d got=%b exp=%b",
                   n, k, st_b, e);
        end
      end
      moe_b = 1'b1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ma = 1'b0; fa = 1'b1; mb = 1'b0; fb = 1'b1;
    moe_a = 1'b0;
    moe_b = 1'b0;
    reset_n = 1'b0;
    ifa.cmd_valid = 1'b0; ifa.cmd_level = 1'b1; ifa.abort = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_level = 1'b1; ifb.abort = 1'b0;
    repeat (3) @(posedge clk_sync);
    #1;
    test_reset();
    @(negedge clk_sync);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sync);
    #1;
    test_pull_low();
    test_stretch();
    test_timeout();
    test_fault();
    test_abort();
    test_async_reset();
    test_random();
    test_arb_lost();
    test_hold0_same_level();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
